// File: rtl/compare_pipe_sgn.sv
// Pipelined signed/unsigned magnitude comparator with valid/ready handshake,
// synchronous flush and a tag sideband. A binary eq/lt reduction tree over
// 1-bit leaves is split into STAGES register stages; the last stage drives
// the outputs directly.
module compare_pipe_sgn #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_a,
    input  logic [N-1:0]     i_b,
    input  logic             i_signed,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_gt,
    output logic [TAG_W-1:0] o_tag
);

    localparam int unsigned L = $clog2(N);
    // Tree levels evaluated per stage; trailing stages may carry zero levels.
    localparam int unsigned K = (STAGES == 0) ? 1 : (L + STAGES - 1) / STAGES;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("compare_pipe_sgn: N must be a power of two >= 2");
    end
    if (STAGES < 1 || STAGES > L) begin : g_bad_stages
        $error("compare_pipe_sgn: STAGES must be in 1..log2(N)");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("compare_pipe_sgn: TAG_W must be >= 1");
    end

    logic [N-1:0]     w_a, w_b;
    logic [N-1:0]     w_st_eq  [STAGES];
    logic [N-1:0]     w_st_lt  [STAGES];
    logic [N-1:0]     w_out_eq [STAGES];
    logic [N-1:0]     w_out_lt [STAGES];
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_vin;
    logic             w_acc;
    logic             w_gt;
    logic             w_unused_hi;

    logic [N-1:0]     r_eq  [STAGES];
    logic [N-1:0]     r_lt  [STAGES];
    logic [TAG_W-1:0] r_tag [STAGES];
    logic [STAGES-1:0] r_v;
    logic             r_gt;
    logic             r_live;

    // Flipping the sign bits maps two's-complement order onto unsigned order.
    assign w_a = i_a ^ {i_signed, {(N-1){1'b0}}};
    assign w_b = i_b ^ {i_signed, {(N-1){1'b0}}};

    // Ready chain: stage s can load if it or any later stage has a hole, or
    // the consumer takes the output beat. Flattened to avoid a self-loop.
    always_comb begin
        logic t_rdy;
        w_rdy = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            t_rdy = i_ready;
            for (int unsigned j = s; j < STAGES; j++) begin
                t_rdy = t_rdy | ~r_v[j];
            end
            w_rdy[s] = t_rdy;
        end
    end

    assign o_ready = r_live & w_rdy[0] & ~i_flush;
    assign w_acc   = i_valid & o_ready;

    // Valid entering each stage.
    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_acc;
        for (int unsigned s = 1; s < STAGES; s++) begin
            w_vin[s] = r_v[s-1];
        end
    end

    // Reduction tree: each stage runs its slice of levels on its input nodes.
    always_comb begin
        logic [N-1:0] t_eq, t_lt, n_eq, n_lt;
        int unsigned  lo, hi;
        w_st_eq[0] = ~(w_a ^ w_b);
        w_st_lt[0] = ~w_a & w_b;
        for (int unsigned s = 1; s < STAGES; s++) begin
            w_st_eq[s] = r_eq[s-1];
            w_st_lt[s] = r_lt[s-1];
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            lo   = (s * K < L) ? s * K : L;
            hi   = ((s + 1) * K < L) ? (s + 1) * K : L;
            t_eq = w_st_eq[s];
            t_lt = w_st_lt[s];
            for (int unsigned lvl = 0; lvl < L; lvl++) begin
                if (lvl >= lo && lvl < hi) begin
                    n_eq = '0;
                    n_lt = '0;
                    for (int unsigned i = 0; i < N / 2; i++) begin
                        n_eq[i] = t_eq[2*i+1] & t_eq[2*i];
                        n_lt[i] = t_lt[2*i+1] | (t_eq[2*i+1] & t_lt[2*i]);
                    end
                    t_eq = n_eq;
                    t_lt = n_lt;
                end
            end
            w_out_eq[s] = t_eq;
            w_out_lt[s] = t_lt;
        end
    end

    assign w_gt = ~w_out_eq[STAGES-1][0] & ~w_out_lt[STAGES-1][0];

    // Ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // Pipeline registers: data only loads with a valid beat so that the
    // outputs hold their last value through bubbles and flushes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v  <= '0;
            r_gt <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_eq[s]  <= '0;
                r_lt[s]  <= '0;
                r_tag[s] <= '0;
            end
        end else if (i_flush) begin
            r_v <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_v[s] <= w_vin[s];
                    if (w_vin[s]) begin
                        r_eq[s]  <= w_out_eq[s];
                        r_lt[s]  <= w_out_lt[s];
                        r_tag[s] <= (s == 0) ? i_tag : r_tag[(s == 0) ? 0 : s - 1];
                        if (s == STAGES - 1) r_gt <= w_gt;
                    end
                end
            end
        end
    end

    assign o_valid = r_v[STAGES-1];
    assign o_eq    = r_eq[STAGES-1][0];
    assign o_lt    = r_lt[STAGES-1][0];
    assign o_gt    = r_gt;
    assign o_tag   = r_tag[STAGES-1];

    // Only the root node of the final stage is meaningful.
    assign w_unused_hi = ^{r_eq[STAGES-1][N-1:1], r_lt[STAGES-1][N-1:1]};

endmodule
